// File: rtl/bj_round_sequencer_pkg.sv
// Shared types and constants for the blackjack round sequencer.
// State encoding, result codes and default game limits live here.
package bj_round_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DEAL_P1 = 4'd1,
    ST_DEAL_D1 = 4'd2,
    ST_DEAL_P2 = 4'd3,
    ST_DEAL_D2 = 4'd4,
    ST_PLAYER  = 4'd5,
    ST_P_DRAW  = 4'd6,
    ST_DEALER  = 4'd7,
    ST_D_DRAW  = 4'd8,
    ST_SETTLE  = 4'd9,
    ST_DONE    = 4'd10
  } state_e;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_LOSE = 2'b01;
  localparam logic [1:0] RES_WIN  = 2'b11;
  localparam logic [1:0] RES_PUSH = 2'b10;

  localparam int DEFAULT_HAND_W       = 6;
  localparam int DEFAULT_DEALER_STAND = 17;
  localparam int DEFAULT_BUST_LIMIT   = 21;

  // States that own an outstanding card request.
  function automatic logic is_draw_state(input state_e s);
    return (s == ST_DEAL_P1) || (s == ST_DEAL_D1) || (s == ST_DEAL_P2) ||
           (s == ST_DEAL_D2) || (s == ST_P_DRAW)  || (s == ST_D_DRAW);
  endfunction

  // Anything outside the legal 2..11 range is scored as a ten.
  function automatic logic [3:0] sanitize_card(input logic [3:0] v);
    return ((v < 4'd2) || (v > 4'd11)) ? 4'd10 : v;
  endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One hand register: sanitises the card, saturating add, optional soft aces.
// Build option: define SOFT_ACE_EN to demote aces from 11 to 1 on overflow.
module bj_hand_accum
  import bj_round_sequencer_pkg::*;
#(
  parameter int HAND_W     = DEFAULT_HAND_W,
  parameter int BUST_LIMIT = DEFAULT_BUST_LIMIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [3:0]        card_i,
  output logic [HAND_W-1:0] total_o,
  output logic [HAND_W-1:0] total_next_o
);

  localparam logic [HAND_W:0] SAT_MAX = {1'b0, {HAND_W{1'b1}}};
  localparam logic [HAND_W:0] BUST_X  = (HAND_W+1)'(BUST_LIMIT);
  localparam logic [HAND_W:0] TEN_X   = (HAND_W+1)'(10);

  logic [HAND_W-1:0] total_q, total_d;
  logic [3:0]        card_s;
  logic [HAND_W:0]   sum_raw;
  logic [HAND_W:0]   sum_adj;
  logic [HAND_W-1:0] sum_sat;

  assign card_s  = sanitize_card(card_i);
  assign sum_raw = {1'b0, total_q} + {{(HAND_W-3){1'b0}}, card_s};

`ifdef SOFT_ACE_EN
  logic [1:0] aces_q, aces_d;
  logic [1:0] aces_inc;
  logic [1:0] aces_after;

  // At most one ace is demoted per incoming card.
  always_comb begin
    aces_inc   = aces_q;
    aces_after = aces_q;
    sum_adj    = sum_raw;
    if ((card_s == 4'd11) && (aces_q != 2'd3)) begin
      aces_inc = aces_q + 2'd1;
    end
    aces_after = aces_inc;
    if ((sum_raw > BUST_X) && (aces_inc != 2'd0)) begin
      sum_adj    = sum_raw - TEN_X;
      aces_after = aces_inc - 2'd1;
    end
  end

  always_comb begin
    aces_d = aces_q;
    if (clr_i) begin
      aces_d = 2'd0;
    end else if (add_i) begin
      aces_d = aces_after;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aces_q <= 2'd0;
    end else begin
      aces_q <= aces_d;
    end
  end
`else
  always_comb begin
    sum_adj = sum_raw;
  end
`endif

  assign sum_sat = (sum_adj > SAT_MAX) ? SAT_MAX[HAND_W-1:0] : sum_adj[HAND_W-1:0];

  always_comb begin
    total_d = total_q;
    if (clr_i) begin
      total_d = '0;
    end else if (add_i) begin
      total_d = sum_sat;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_o      = total_q;
  assign total_next_o = sum_sat;

endmodule

// File: rtl/bj_round_sequencer.sv
// Blackjack round controller: deal, player turn, dealer auto-draw, settle.
// Honours SOFT_ACE_EN through the bj_hand_accum instances.
module bj_round_sequencer
  import bj_round_sequencer_pkg::*;
#(
  parameter int HAND_W       = DEFAULT_HAND_W,
  parameter int DEALER_STAND = DEFAULT_DEALER_STAND,
  parameter int BUST_LIMIT   = DEFAULT_BUST_LIMIT
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hit,
  input  logic              stand,
  output logic              card_req,
  input  logic              card_ack,
  input  logic [3:0]        card_val,
  output logic              card_to_dealer,
  output logic [HAND_W-1:0] phand,
  output logic [HAND_W-1:0] dhand,
  output logic [1:0]        result,
  output logic              busy,
  output logic [3:0]        dbg_state_o
);

  localparam logic [HAND_W-1:0] BUST_H  = HAND_W'(BUST_LIMIT);
  localparam logic [HAND_W-1:0] STAND_H = HAND_W'(DEALER_STAND);

  // Card handshake: card_req is held high in a draw state until the cycle
  // card_ack is seen with card_req high; that cycle transfers card_val.
  // card_req is registered and drops the cycle after the transfer, so two
  // requests are always separated by at least one low cycle.
  state_e            state_q, state_d;
  logic              card_req_q, card_req_d;
  logic [1:0]        result_q, result_d;
  logic              accept;
  logic              p_add, d_add, hands_clr;
  logic [HAND_W-1:0] p_next, d_next;

  assign accept    = card_req_q & card_ack;
  assign hands_clr = ((state_q == ST_IDLE) || (state_q == ST_DONE)) & start;
  assign p_add     = accept & ((state_q == ST_DEAL_P1) || (state_q == ST_DEAL_P2) ||
                               (state_q == ST_P_DRAW));
  assign d_add     = accept & ((state_q == ST_DEAL_D1) || (state_q == ST_DEAL_D2) ||
                               (state_q == ST_D_DRAW));

  bj_hand_accum #(.HAND_W(HAND_W), .BUST_LIMIT(BUST_LIMIT)) u_player (
    .clk_i        (Clock),
    .rst_i        (reset),
    .clr_i        (hands_clr),
    .add_i        (p_add),
    .card_i       (card_val),
    .total_o      (phand),
    .total_next_o (p_next)
  );

  bj_hand_accum #(.HAND_W(HAND_W), .BUST_LIMIT(BUST_LIMIT)) u_dealer (
    .clk_i        (Clock),
    .rst_i        (reset),
    .clr_i        (hands_clr),
    .add_i        (d_add),
    .card_i       (card_val),
    .total_o      (dhand),
    .total_next_o (d_next)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_DEAL_P1;
          result_d = RES_NONE;
        end
      end
      ST_DEAL_P1: if (accept) state_d = ST_DEAL_D1;
      ST_DEAL_D1: if (accept) state_d = ST_DEAL_P2;
      ST_DEAL_P2: if (accept) state_d = ST_DEAL_D2;
      ST_DEAL_D2: if (accept) state_d = ST_PLAYER;
      ST_PLAYER: begin
        // stand beats a simultaneous hit; a hand sitting at the limit may only stand
        if (stand) begin
          state_d = ST_DEALER;
        end else if (hit && (phand != BUST_H)) begin
          state_d = ST_P_DRAW;
        end
      end
      ST_P_DRAW: begin
        if (accept) begin
          if (p_next > BUST_H) begin
            state_d  = ST_DONE;
            result_d = RES_LOSE;
          end else begin
            state_d = ST_PLAYER;
          end
        end
      end
      ST_DEALER: state_d = (dhand < STAND_H) ? ST_D_DRAW : ST_SETTLE;
      ST_D_DRAW: if (accept) state_d = ST_DEALER;
      ST_SETTLE: begin
        state_d = ST_DONE;
        if (dhand > BUST_H) begin
          result_d = RES_WIN;
        end else if (phand > dhand) begin
          result_d = RES_WIN;
        end else if (phand == dhand) begin
          result_d = RES_PUSH;
        end else begin
          result_d = RES_LOSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign card_req_d = is_draw_state(state_d) & ~accept;

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      card_req_q <= 1'b0;
      result_q   <= RES_NONE;
    end else begin
      state_q    <= state_d;
      card_req_q <= card_req_d;
      result_q   <= result_d;
    end
  end

  assign card_req       = card_req_q;
  assign card_to_dealer = (state_q == ST_DEAL_D1) || (state_q == ST_DEAL_D2) ||
                          (state_q == ST_D_DRAW);
  assign result         = result_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_bj_round_sequencer.sv
// Self-checking bench for bj_round_sequencer: scripted rounds with a card
// responder, a result scoreboard and card_req pulse counting.
module tb_bj_round_sequencer;
  import bj_round_sequencer_pkg::*;

  localparam int HW = 6;

  logic          Clock = 1'b0;
  logic          reset;
  logic          start, hit, stand;
  logic          card_ack;
  logic [3:0]    card_val;
  logic          card_req, card_to_dealer;
  logic [HW-1:0] phand, dhand;
  logic [1:0]    result;
  logic          busy;
  logic [3:0]    dbg_state;

  int checks     = 0;
  int failures   = 0;
  int req_pulses = 0;
  logic req_prev = 1'b0;

  logic [2*HW+1:0] exp_q[$];

  always #5 Clock = ~Clock;

  bj_round_sequencer dut (
    .Clock          (Clock),
    .reset          (reset),
    .start          (start),
    .hit            (hit),
    .stand          (stand),
    .card_req       (card_req),
    .card_ack       (card_ack),
    .card_val       (card_val),
    .card_to_dealer (card_to_dealer),
    .phand          (phand),
    .dhand          (dhand),
    .result         (result),
    .busy           (busy),
    .dbg_state_o    (dbg_state)
  );

  always @(negedge Clock) begin
    if (card_req && !req_prev) req_pulses++;
    req_prev = card_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic pulse_play(input logic h, input logic s);
    hit   = h;
    stand = s;
    @(negedge Clock);
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  task automatic serve(input logic [3:0] v, input logic to_d, input string tag);
    int n = 0;
    while (!card_req && n < 40) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_req"}, 32'(card_req), 32'd1);
    check({tag, "_dest"}, 32'(card_to_dealer), 32'(to_d));
    card_val = v;
    card_ack = 1'b1;
    @(negedge Clock);
    card_ack = 1'b0;
    card_val = 4'd0;
    check({tag, "_gap"}, 32'(card_req), 32'd0);
  endtask

  task automatic deal(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    serve(a, 1'b0, "p1");
    serve(b, 1'b1, "d1");
    serve(c, 1'b0, "p2");
    serve(d, 1'b1, "d2");
  endtask

  task automatic expect_round(input int p, input int d, input logic [1:0] r);
    exp_q.push_back({HW'(p), HW'(d), r});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    logic [2*HW+1:0] e;
    while (busy && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_phand"}, 32'(phand), 32'(e[2*HW+1:HW+2]));
      check({tag, "_dhand"}, 32'(dhand), 32'(e[HW+1:2]));
      check({tag, "_result"}, 32'(result), 32'(e[1:0]));
    end
  endtask

  int p0;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    hit      = 1'b0;
    stand    = 1'b0;
    card_ack = 1'b0;
    card_val = 4'd0;
    repeat (3) @(negedge Clock);
    check("rst_req", 32'(card_req), 32'd0);
    check("rst_phand", 32'(phand), 32'd0);
    check("rst_dhand", 32'(dhand), 32'd0);
    check("rst_result", 32'(result), 32'(RES_NONE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dest", 32'(card_to_dealer), 32'd0);
    reset = 1'b0;
    @(negedge Clock);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Push round: 17 v 17, stand, no dealer draw; start ignored while busy
    p0 = req_pulses;
    expect_round(17, 17, RES_PUSH);
    pulse_start();
    check("push_busy", 32'(busy), 32'd1);
    deal(4'd10, 4'd9, 4'd7, 4'd8);
    check("push_p", 32'(phand), 32'd17);
    check("push_d", 32'(dhand), 32'd17);
    check("push_state", 32'(dbg_state), 32'(ST_PLAYER));
    pulse_start();
    check("busy_start_ign", 32'(dbg_state), 32'(ST_PLAYER));
    pulse_play(1'b0, 1'b1);
    wait_done("push");
    #1 check("push_pulses", 32'(req_pulses - p0), 32'd4);

    // Player bust: 19, hit 5 -> 24, dealer never draws
    @(negedge Clock);
    p0 = req_pulses;
    expect_round(24, 11, RES_LOSE);
    pulse_start();
    check("bust_clr_p", 32'(phand), 32'd0);
    check("bust_clr_r", 32'(result), 32'(RES_NONE));
    deal(4'd10, 4'd6, 4'd9, 4'd5);
    pulse_play(1'b1, 1'b0);
    check("hit_latency", 32'(card_req), 32'd1);
    serve(4'd5, 1'b0, "ph");
    wait_done("pbust");
    #1 check("pbust_pulses", 32'(req_pulses - p0), 32'd5);

    // Dealer draws from 16 and busts
    @(negedge Clock);
    p0 = req_pulses;
    expect_round(19, 26, RES_WIN);
    pulse_start();
    deal(4'd10, 4'd10, 4'd9, 4'd6);
    pulse_play(1'b0, 1'b1);
    serve(4'd10, 1'b1, "dd");
    wait_done("dbust");
    #1 check("dbust_pulses", 32'(req_pulses - p0), 32'd5);

    // hit and stand together: stand wins
    @(negedge Clock);
    p0 = req_pulses;
    expect_round(19, 18, RES_WIN);
    pulse_start();
    deal(4'd10, 4'd10, 4'd9, 4'd8);
    pulse_play(1'b1, 1'b1);
    check("hs_state", 32'(dbg_state), 32'(ST_DEALER));
    check("hs_noreq", 32'(card_req), 32'd0);
    wait_done("hs");
    #1 check("hs_pulses", 32'(req_pulses - p0), 32'd4);

    // Out-of-range cards score as ten
    @(negedge Clock);
    expect_round(12, 20, RES_LOSE);
    pulse_start();
    deal(4'd0, 4'd10, 4'd2, 4'd15);
    check("san_p", 32'(phand), 32'd12);
    check("san_d", 32'(dhand), 32'd20);
    pulse_play(1'b0, 1'b1);
    wait_done("san");

    // Two player aces
    @(negedge Clock);
`ifdef SOFT_ACE_EN
    expect_round(12, 17, RES_LOSE);
`else
    expect_round(22, 17, RES_WIN);
`endif
    pulse_start();
    deal(4'd11, 4'd10, 4'd11, 4'd7);
    pulse_play(1'b0, 1'b1);
    wait_done("aces");

    // Hand at 21: hit ignored
    @(negedge Clock);
    expect_round(21, 17, RES_WIN);
    pulse_start();
    deal(4'd10, 4'd10, 4'd11, 4'd7);
    pulse_play(1'b1, 1'b0);
    check("h21_state", 32'(dbg_state), 32'(ST_PLAYER));
    check("h21_noreq", 32'(card_req), 32'd0);
    pulse_play(1'b0, 1'b1);
    wait_done("h21");

    // Reset mid-draw while card_req is high in P_DRAW
    @(negedge Clock);
    pulse_start();
    deal(4'd10, 4'd10, 4'd5, 4'd7);
    pulse_play(1'b1, 1'b0);
    check("mid_state", 32'(dbg_state), 32'(ST_P_DRAW));
    check("mid_req", 32'(card_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_req_drop", 32'(card_req), 32'd0);
    check("mid_phand", 32'(phand), 32'd0);
    check("mid_dhand", 32'(dhand), 32'd0);
    check("mid_result", 32'(result), 32'(RES_NONE));
    card_ack = 1'b1;
    card_val = 4'd9;
    @(negedge Clock);
    card_ack = 1'b0;
    reset    = 1'b0;
    @(negedge Clock);
    check("mid_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_phand2", 32'(phand), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
